hamming_decoder_12to8: RTL and testbench
========================================

# hamming_decoder_12to8

Pipelined Hamming(12,8) single-error-correcting decoder for the dual-port memory read path. It takes 12-bit codewords from the array in the layout `hamming_encoder_8to12` produces and returns corrected 8-bit data with per-word error flags. Two register stages with valid/ready flow control let it sit between the memory read port and the consumer. Saturating event counters give ECC health statistics.

## Interface
Parameters:
- CNT_W, 16, width of the corrected and uncorrectable event counters.

Ports:
- clk  in  1  single clock; all state is updated on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  codeword on in_code is valid.
- in_ready  out  1  decoder accepts in_code this cycle.
- in_code  in  12  codeword, encoder layout.
- out_valid  out  1  out_data and the flags are valid.
- out_ready  in  1  consumer accepts the output.
- out_data  out  8  corrected data.
- out_corr  out  1  single-bit error found and corrected.
- out_uncorr  out  1  syndrome points outside the codeword (13–15); data is passed through uncorrected.
- out_syn  out  4  raw syndrome, for debug.
- clr_cnt  in  1  synchronous clear of both counters.
- corr_cnt  out  CNT_W  saturating count of corrected words.
- uncorr_cnt  out  CNT_W  saturating count of uncorrectable words.

## Operation
- **Codeword layout:** bit i is Hamming position i+1.
  - Parity bits are at bits 0, 1, 3 and 7.
  - Data d0..d7 are at bits 2, 4, 5, 6, 8, 9, 10, 11.
- **Syndrome:**
  - s0 = c0^c2^c4^c6^c8^c10
  - s1 = c1^c2^c5^c6^c9^c10
  - s2 = c3^c4^c5^c6^c11
  - s3 = c7^c8^c9^c10^c11
  - S = {s3,s2,s1,s0}.
- **Classification:**
  - S=0: clean.
  - S=1..12: flip codeword bit S-1 and assert out_corr. This includes parity-only errors, where the data is unchanged but out_corr is still asserted.
  - S=13..15: assert out_uncorr; data is extracted from the uncorrected word.
- There is no double-error detection. A double error that yields S≤12 is miscorrected, and that is the specified behaviour.
- **Stage 1** registers the codeword and its syndrome.
- **Stage 2** registers the corrected data, flags and syndrome.
- **Counters:**
  - A counter increments only on an output transfer (out_valid && out_ready) whose matching flag is set.
  - Counters saturate at all-ones.
  - When clr_cnt and an increment occur in the same cycle, clr_cnt wins and the result is 0.

## Timing
- **Reset values:** in_ready=1 from the first cycle after reset. out_valid=0, out_data=0, out_corr=0, out_uncorr=0, out_syn=0, corr_cnt=0, uncorr_cnt=0. Stage valid bits are 0.
- **Latency:** a codeword accepted in cycle N presents out_valid in cycle N+2.
- **Throughput:** one word per cycle when out_ready is held at 1.
- **Stage advance rules:**
  - adv2 = !out_valid || out_ready
  - adv1 = !s1_valid || adv2
  - in_ready = adv1
  - in_ready is combinational from out_ready.
- While out_valid=1 and out_ready=0, out_data, the flags and out_syn stay stable.
- A reset mid-stream drops all in-flight words. No partial outputs appear after reset.
- Payload registers update only when their stage advances. Valid bits are the only state that needs reset, but payload is also reset so the outputs read 0.

## Structure
- **Package `hamming_pkg`:**
  - Constants: CODE_W=12, DATA_W=8, SYN_W=4.
  - Data-position constant array {2,4,5,6,8,9,10,11}.
  - Functions `hamming_syndrome(code)` and `hamming_extract(code)`.
  - The package is shared with the encoder.
- **Sub-module `hamming_syndrome_12`:** combinational, 12-bit code in, 4-bit syndrome out. Stage 1 instantiates it.
- **Top:** pipeline registers, correction mux and counters.

## Test plan
Reference codeword: data 0xA5 encodes to 0xA27.
- **Clean word:** in_code=0xA27 -> two cycles later out_data=0xA5, out_syn=0, out_corr=0, out_uncorr=0.
- **Data-bit error:** in_code=0xA07 (bit 5 flipped) -> out_data=0xA5, out_syn=6, out_corr=1, and corr_cnt increments by 1 on the transfer.
- **Parity-bit error:** in_code=0xA26 (bit 0 flipped) -> out_data=0xA5, out_syn=1, out_corr=1.
- **Uncorrectable:** in_code=0x225 (bits 11 and 1 flipped) -> out_syn=14, out_uncorr=1, out_data=0x25, and uncorr_cnt increments.
- **Backpressure:**
  - Stream 4 words with out_ready=0 -> in_ready drops after 2 accepts, and the outputs hold stable.
  - Raise out_ready -> all 4 words emerge in order with no loss or duplication.
- **Counters:**
  - Preload corr_cnt to all-ones via 2^CNT_W corrected words (or CNT_W=4 in the bench) -> the count stays at 15.
  - Assert clr_cnt together with a corrected transfer -> corr_cnt=0.
  - Assert rst_n low mid-stream -> out_valid=0 the next cycle and the counters are 0.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared Hamming(12,8) definitions: codeword geometry, syndrome and data extraction.
// Used by both the encoder and the decoder so the bit layout lives in one place.
package hamming_pkg;

  localparam int CODE_W = 12;
  localparam int DATA_W = 8;
  localparam int SYN_W  = 4;

  // Codeword bit index of data bit d0..d7; parity sits at the powers of two minus one.
  localparam int DATA_POS [DATA_W] = '{2, 4, 5, 6, 8, 9, 10, 11};

  function automatic logic [SYN_W-1:0] hamming_syndrome(input logic [CODE_W-1:0] code);
    logic [SYN_W-1:0] s;
    s[0] = code[0] ^ code[2] ^ code[4] ^ code[6] ^ code[8] ^ code[10];
    s[1] = code[1] ^ code[2] ^ code[5] ^ code[6] ^ code[9] ^ code[10];
    s[2] = code[3] ^ code[4] ^ code[5] ^ code[6] ^ code[11];
    s[3] = code[7] ^ code[8] ^ code[9] ^ code[10] ^ code[11];
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] hamming_extract(input logic [CODE_W-1:0] code);
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W; i++) begin
      d[i] = code[DATA_POS[i]];
    end
    return d;
  endfunction

endpackage

// File: rtl/hamming_syndrome_12.sv
// Combinational syndrome generator for a 12-bit Hamming codeword.
module hamming_syndrome_12
  import hamming_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [SYN_W-1:0]  syn
);

  assign syn = hamming_syndrome(code);

endmodule

// File: rtl/hamming_decoder_12to8.sv
// Two-stage Hamming(12,8) SEC decoder with valid/ready flow control and
// saturating corrected/uncorrectable event counters.
module hamming_decoder_12to8
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_corr,
  output logic              out_uncorr,
  output logic [SYN_W-1:0]  out_syn,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  localparam logic [SYN_W-1:0] SYN_MAX = SYN_W'(CODE_W);

  function automatic logic [CODE_W-1:0] correct_code(input logic [CODE_W-1:0] code,
                                                     input logic [SYN_W-1:0]  syn);
    logic [CODE_W-1:0] fixed;
    fixed = code;
    for (int i = 0; i < CODE_W; i++) begin
      if (syn == SYN_W'(i + 1)) fixed[i] = ~code[i];
    end
    return fixed;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == '1) ? cnt : cnt + 1'b1;
  endfunction

  logic              adv1, adv2, xfer;
  logic [SYN_W-1:0]  syn_p0;
  logic              vld_p1;
  logic [CODE_W-1:0] code_p1;
  logic [SYN_W-1:0]  syn_p1;
  logic              corr_p1, uncorr_p1;

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !vld_p1 || adv2;
  assign in_ready = adv1;
  assign xfer     = out_valid && out_ready;

  hamming_syndrome_12 u_syn (
    .code (in_code),
    .syn  (syn_p0)
  );

  // Stage 1: capture codeword and its syndrome
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      code_p1 <= '0;
      syn_p1  <= '0;
    end else if (adv1) begin
      vld_p1  <= in_valid;
      code_p1 <= in_code;
      syn_p1  <= syn_p0;
    end
  end

  assign corr_p1   = (syn_p1 != '0) && (syn_p1 <= SYN_MAX);
  assign uncorr_p1 = (syn_p1 > SYN_MAX);

  // Stage 2: corrected data, flags and debug syndrome
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_corr   <= 1'b0;
      out_uncorr <= 1'b0;
      out_syn    <= '0;
    end else if (adv2) begin
      out_valid  <= vld_p1;
      out_data   <= hamming_extract(correct_code(code_p1, syn_p1));
      out_corr   <= corr_p1;
      out_uncorr <= uncorr_p1;
      out_syn    <= syn_p1;
    end
  end

  // Counters see only completed transfers; clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_cnt) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (xfer) begin
      if (out_corr)   corr_cnt   <= sat_inc(corr_cnt);
      if (out_uncorr) uncorr_cnt <= sat_inc(uncorr_cnt);
    end
  end

endmodule

// File: tb/tb_hamming_decoder_12to8.sv
// Directed self-checking bench for hamming_decoder_12to8 (counters narrowed to 4 bits).
module tb_hamming_decoder_12to8;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n, in_valid, in_ready, out_valid, out_ready;
  logic             out_corr, out_uncorr, clr_cnt;
  logic [11:0]      in_code;
  logic [7:0]       out_data;
  logic [3:0]       out_syn;
  logic [CNT_W-1:0] corr_cnt, uncorr_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hamming_decoder_12to8 #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_corr   (out_corr),
    .out_uncorr (out_uncorr),
    .out_syn    (out_syn),
    .clr_cnt    (clr_cnt),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [11:0] code);
    in_code = code; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0; in_code = '0;
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
    checks++; if ({out_corr, out_uncorr, out_syn} !== 6'b0) begin errors++; $display("FAIL reset_flags: got %b%b %h expected 00 0", out_corr, out_uncorr, out_syn); end
    checks++; if (corr_cnt !== '0 || uncorr_cnt !== '0) begin errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", corr_cnt, uncorr_cnt); end
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_clean();
    in_code = 12'hA27; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early: got out_valid %b expected 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clean_valid: got %b expected 1", out_valid); end
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL clean_data: got %h expected a5", out_data); end
    checks++; if (out_syn !== 4'd0 || out_corr !== 1'b0 || out_uncorr !== 1'b0) begin errors++; $display("FAIL clean_flags: got syn %0d corr %b uncorr %b expected 0 0 0", out_syn, out_corr, out_uncorr); end
    tick();
    checks++; if (out_valid !== 1'b0 || corr_cnt !== 4'd0) begin errors++; $display("FAIL clean_after: got valid %b corr_cnt %0d expected 0 0", out_valid, corr_cnt); end
  endtask

  task automatic test_data_err();
    push_word(12'hA07);
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL data_err_data: got %h expected a5", out_data); end
    checks++; if (out_syn !== 4'd6 || out_corr !== 1'b1 || out_uncorr !== 1'b0) begin errors++; $display("FAIL data_err_flags: got syn %0d corr %b uncorr %b expected 6 1 0", out_syn, out_corr, out_uncorr); end
    tick();
    checks++; if (corr_cnt !== 4'd1) begin errors++; $display("FAIL data_err_cnt: got %0d expected 1", corr_cnt); end
  endtask

  task automatic test_parity_err();
    push_word(12'hA26);
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL parity_err_data: got %h expected a5", out_data); end
    checks++; if (out_syn !== 4'd1 || out_corr !== 1'b1 || out_uncorr !== 1'b0) begin errors++; $display("FAIL parity_err_flags: got syn %0d corr %b uncorr %b expected 1 1 0", out_syn, out_corr, out_uncorr); end
    tick();
    checks++; if (corr_cnt !== 4'd2) begin errors++; $display("FAIL parity_err_cnt: got %0d expected 2", corr_cnt); end
  endtask

  task automatic test_uncorr();
    push_word(12'h225);
    checks++; if (out_data !== 8'h25) begin errors++; $display("FAIL uncorr_data: got %h expected 25", out_data); end
    checks++; if (out_syn !== 4'd14 || out_corr !== 1'b0 || out_uncorr !== 1'b1) begin errors++; $display("FAIL uncorr_flags: got syn %0d corr %b uncorr %b expected 14 0 1", out_syn, out_corr, out_uncorr); end
    tick();
    checks++; if (uncorr_cnt !== 4'd1 || corr_cnt !== 4'd2) begin errors++; $display("FAIL uncorr_cnt: got uncorr %0d corr %0d expected 1 2", uncorr_cnt, corr_cnt); end
  endtask

  task automatic test_backpressure();
    logic [11:0] words [4];
    logic [7:0]  exp   [4];
    logic [7:0]  got   [4];
    int k, n;
    logic acc, xf;
    logic [7:0] d;
    words = '{12'hA27, 12'hF77, 12'h550, 12'h000};
    exp   = '{8'hA5, 8'hFF, 8'h5A, 8'h00};
    k = 0; n = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (k < 4);
      in_code  = words[(k < 4) ? k : 0];
      #1;
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) k++;
      #1;
    end
    checks++; if (k !== 2) begin errors++; $display("FAIL bp_accepts: got %0d expected 2", k); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
    for (int c = 0; c < 3; c++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_syn !== 4'd0) begin errors++; $display("FAIL bp_hold: got valid %b data %h syn %0d expected 1 a5 0", out_valid, out_data, out_syn); end
      tick();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && n < 4; c++) begin
      in_valid = (k < 4);
      in_code  = words[(k < 4) ? k : 0];
      #1;
      acc = in_valid && in_ready;
      xf  = out_valid && out_ready;
      d   = out_data;
      @(posedge clk);
      if (acc) k++;
      if (xf) begin got[n] = d; n++; end
      #1;
    end
    in_valid = 1'b0;
    checks++; if (n !== 4) begin errors++; $display("FAIL bp_count: got %0d words expected 4", n); end
    for (int i = 0; i < 4; i++) begin
      if (i < n) begin
        checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL bp_order[%0d]: got %h expected %h", i, got[i], exp[i]); end
      end
    end
    repeat (2) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got out_valid %b expected 0", out_valid); end
  endtask

  task automatic test_counters();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    checks++; if (corr_cnt !== 4'd0 || uncorr_cnt !== 4'd0) begin errors++; $display("FAIL clr_cnt: got %0d/%0d expected 0/0", corr_cnt, uncorr_cnt); end
    in_code = 12'hA07; in_valid = 1'b1; out_ready = 1'b1;
    repeat (17) tick();
    in_valid = 1'b0;
    repeat (3) tick();
    checks++; if (corr_cnt !== 4'd15) begin errors++; $display("FAIL sat_cnt: got %0d expected 15", corr_cnt); end
    checks++; if (uncorr_cnt !== 4'd0) begin errors++; $display("FAIL sat_uncorr: got %0d expected 0", uncorr_cnt); end
    push_word(12'hA07);
    checks++; if (out_valid !== 1'b1 || out_corr !== 1'b1) begin errors++; $display("FAIL clr_xfer_setup: got valid %b corr %b expected 1 1", out_valid, out_corr); end
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    checks++; if (corr_cnt !== 4'd0) begin errors++; $display("FAIL clr_wins: got %0d expected 0", corr_cnt); end
    tick();
    checks++; if (corr_cnt !== 4'd0) begin errors++; $display("FAIL clr_after: got %0d expected 0", corr_cnt); end
  endtask

  task automatic test_reset_midstream();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_code = (i % 2 == 0) ? 12'hA07 : 12'h225;
      tick();
    end
    checks++; if (corr_cnt !== 4'd2 || uncorr_cnt !== 4'd2 || out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset: got corr %0d uncorr %0d valid %b expected 2 2 1", corr_cnt, uncorr_cnt, out_valid); end
    rst_n = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL mid_reset_out: got valid %b data %h expected 0 00", out_valid, out_data); end
    checks++; if ({out_corr, out_uncorr, out_syn} !== 6'b0) begin errors++; $display("FAIL mid_reset_flags: got %b%b %h expected 00 0", out_corr, out_uncorr, out_syn); end
    checks++; if (corr_cnt !== 4'd0 || uncorr_cnt !== 4'd0) begin errors++; $display("FAIL mid_reset_cnt: got %0d/%0d expected 0/0", corr_cnt, uncorr_cnt); end
    rst_n = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: cycle %0d got %b expected 0", i, out_valid); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within time budget");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_clean();
    test_data_err();
    test_parity_err();
    test_uncorr();
    test_backpressure();
    test_counters();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
